// File: rtl/gray_writer_pkg.sv
// rtl/gray_writer_pkg.sv - shared types and helpers for the grayscale burst writer
// Purpose: FSM state encoding, bytes-per-word constant and the byte-reversal
//          helper used by gray_burst_writer and gray_word_fifo.
package gray_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_REQ,
    ST_BURST,
    ST_DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // Reverse byte order of a packed 4-pixel word (big-endian CPU view).
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/gray_word_fifo.sv
// rtl/gray_word_fifo.sv - synchronous word FIFO with flush for the burst writer
// Purpose: buffers grayscale words between the pixel input and the bus burst.
// Ports:
//   i_clock, i_nReset   clock, asynchronous active-low reset
//   i_flush             discard contents (wins over push/pop)
//   i_push, i_push_data write one word; visible at o_head next cycle when empty
//   i_pop               drop the head word
//   o_head              current head word
//   o_count             words held (0..DEPTH)
//   o_full              count == DEPTH
module gray_word_fifo
  import gray_writer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                       i_clock,
  input  logic                       i_nReset,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge i_clock) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == (AW+1)'(DEPTH));

  // The writer only pops after checking the FIFO holds a full burst.
  assert property (@(posedge i_clock) disable iff (!i_nReset)
                   !(i_pop && !i_flush && (r_count == '0)));

endmodule

// File: rtl/gray_burst_writer.sv
// rtl/gray_burst_writer.sv - buffers packed grayscale words and writes them in bus bursts
// Purpose: accepts 32-bit words (4 pixels), counts them against a per-frame
//          budget and writes them to memory with request/grant bursts.
// Optional feature macro: GRAY_BURST_WRITER_BYTESWAP_EN (byte-reversed bus data).
// Ports:
//   i_clock, i_nReset                 clock, asynchronous active-low reset
//   i_frameStart, i_baseAddress,      frame restart pulse, base address,
//   i_frameWords                      word budget (0 = immediate done)
//   i_pixelValid, i_pixelWord,        input word stream
//   o_pixelReady
//   o_busRequest, i_busGrant,         bus master request/grant, burst address
//   o_busAddress, o_busBurstLen       and beat count
//   o_busData, o_busDataValid,        write beats, held while i_busBusy
//   i_busBusy
//   o_frameDone                       pulse after the last beat of a frame
//   o_overflow                        sticky: word offered past the budget
module gray_burst_writer
  import gray_writer_pkg::*;
#(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        i_clock,
  input  logic        i_nReset,
  input  logic        i_frameStart,
  input  logic [31:0] i_baseAddress,
  input  logic [15:0] i_frameWords,
  input  logic        i_pixelValid,
  input  logic [31:0] i_pixelWord,
  output logic        o_pixelReady,
  output logic        o_busRequest,
  input  logic        i_busGrant,
  output logic [31:0] o_busAddress,
  output logic [4:0]  o_busBurstLen,
  output logic [31:0] o_busData,
  output logic        o_busDataValid,
  input  logic        i_busBusy,
  output logic        o_frameDone,
  output logic        o_overflow
);

  localparam int          CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BL16 = 16'(BURST_LEN);
  localparam logic [4:0]  BL5  = 5'(BURST_LEN);

  state_t      r_state;
  logic [31:0] r_addr;
  logic [15:0] r_remaining;
  logic [15:0] r_frame_words;
  logic [15:0] r_accepted;
  logic [4:0]  r_beat;
  logic        r_bus_request;
  logic        r_bus_data_valid;
  logic [31:0] r_bus_address;
  logic [4:0]  r_bus_burst_len;
  logic        r_frame_done;
  logic        r_overflow;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_last_beat;
  logic [31:0]   w_head;
  logic [31:0]   w_bus_word;
  logic [CW-1:0] w_count;
  logic [15:0]   w_count16;
  logic          w_full;
  logic [4:0]    w_next_len;
  logic [1:0]    w_unused_addr_bits;

  assign w_unused_addr_bits = i_baseAddress[1:0];

  assign w_ready   = (r_state != ST_IDLE) && !w_full && (r_accepted < r_frame_words);
  assign w_push    = i_pixelValid && w_ready && !i_frameStart;
  assign w_pop     = (r_state == ST_BURST) && !i_busBusy && !i_frameStart;
  assign w_count16 = 16'(w_count);
  assign w_next_len  = (r_remaining >= BL16) ? BL5 : r_remaining[4:0];
  assign w_last_beat = (r_beat == r_bus_burst_len - 5'd1);

  gray_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clock     (i_clock),
    .i_nReset    (i_nReset),
    .i_flush     (i_frameStart),
    .i_push      (w_push),
    .i_push_data (i_pixelWord),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full)
  );

  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      r_state          <= ST_IDLE;
      r_addr           <= '0;
      r_remaining      <= '0;
      r_frame_words    <= '0;
      r_accepted       <= '0;
      r_beat           <= '0;
      r_bus_request    <= 1'b0;
      r_bus_data_valid <= 1'b0;
      r_bus_address    <= '0;
      r_bus_burst_len  <= '0;
      r_frame_done     <= 1'b0;
      r_overflow       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_push) r_accepted <= r_accepted + 16'd1;
      // Only words past the frame budget count as overflow, not FIFO-full stalls.
      if (i_pixelValid && (r_state != ST_IDLE) && (r_accepted >= r_frame_words))
        r_overflow <= 1'b1;

      if (i_frameStart) begin
        r_state          <= ST_FILL;
        r_addr           <= {i_baseAddress[31:2], 2'b00};
        r_remaining      <= i_frameWords;
        r_frame_words    <= i_frameWords;
        r_accepted       <= '0;
        r_overflow       <= 1'b0;
        r_beat           <= '0;
        r_bus_request    <= 1'b0;
        r_bus_data_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_IDLE;
          ST_FILL: begin
            if (r_remaining == 16'd0) begin
              r_state      <= ST_DONE;
              r_frame_done <= 1'b1;
            end else if ((w_count16 >= BL16) || (w_count16 >= r_remaining)) begin
              // Second term catches the tail burst once every remaining word is buffered.
              r_state         <= ST_REQ;
              r_bus_request   <= 1'b1;
              r_bus_address   <= r_addr;
              r_bus_burst_len <= w_next_len;
            end
          end
          ST_REQ: begin
            if (i_busGrant) begin
              r_state          <= ST_BURST;
              r_bus_data_valid <= 1'b1;
              r_beat           <= '0;
            end
          end
          ST_BURST: begin
            if (w_pop) begin
              if (w_last_beat) begin
                r_addr           <= r_addr + 32'(r_bus_burst_len) * 32'(BYTES_PER_WORD);
                r_remaining      <= r_remaining - 16'(r_bus_burst_len);
                r_bus_request    <= 1'b0;
                r_bus_data_valid <= 1'b0;
                if (r_remaining == 16'(r_bus_burst_len)) begin
                  r_state      <= ST_DONE;
                  r_frame_done <= 1'b1;
                end else begin
                  r_state <= ST_FILL;
                end
              end else begin
                r_beat <= r_beat + 5'd1;
              end
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef GRAY_BURST_WRITER_BYTESWAP_EN
  assign w_bus_word = byte_swap(w_head);
`else
  assign w_bus_word = w_head;
`endif

  assign o_pixelReady   = w_ready;
  assign o_busRequest   = r_bus_request;
  assign o_busAddress   = r_bus_address;
  assign o_busBurstLen  = r_bus_burst_len;
  assign o_busDataValid = r_bus_data_valid;
  // Gate the head so the bus sees zero outside a burst (FIFO storage is not reset).
  assign o_busData      = r_bus_data_valid ? w_bus_word : 32'd0;
  assign o_frameDone    = r_frame_done;
  assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_gray_burst_writer.sv
// tb/tb_gray_burst_writer.sv - self-checking bench for gray_burst_writer
module tb_gray_burst_writer;

  localparam int BL = 8;

  logic        clk;
  logic        i_nReset;
  logic        i_frameStart;
  logic [31:0] i_baseAddress;
  logic [15:0] i_frameWords;
  logic        i_pixelValid;
  logic [31:0] i_pixelWord;
  logic        o_pixelReady;
  logic        o_busRequest;
  logic        i_busGrant;
  logic [31:0] o_busAddress;
  logic [4:0]  o_busBurstLen;
  logic [31:0] o_busData;
  logic        o_busDataValid;
  logic        i_busBusy;
  logic        o_frameDone;
  logic        o_overflow;

  gray_burst_writer #(.BURST_LEN(BL), .FIFO_DEPTH(16)) dut (
    .i_clock        (clk),
    .i_nReset       (i_nReset),
    .i_frameStart   (i_frameStart),
    .i_baseAddress  (i_baseAddress),
    .i_frameWords   (i_frameWords),
    .i_pixelValid   (i_pixelValid),
    .i_pixelWord    (i_pixelWord),
    .o_pixelReady   (o_pixelReady),
    .o_busRequest   (o_busRequest),
    .i_busGrant     (i_busGrant),
    .o_busAddress   (o_busAddress),
    .o_busBurstLen  (o_busBurstLen),
    .o_busData      (o_busData),
    .o_busDataValid (o_busDataValid),
    .i_busBusy      (i_busBusy),
    .o_frameDone    (o_frameDone),
    .o_overflow     (o_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  len;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] rec_addr[$];
  logic [4:0]  rec_len[$];
  logic [31:0] rec_data[$];

  int checks = 0;
  int failures = 0;
  int sa = 1000;
  int first_req_lat = -1;
  int done_cnt = 0;
  int done_sa = -1;
  int beats_frame = 0;
  int stall_beat = -1;
  int stall_left = 0;
  int busy_cycles = 0;
  logic mon_en = 1'b0;
  logic last_prev = 1'b0;
  logic prev_valid = 1'b0;
  logic zero_frame = 1'b0;
  logic ovf_model = 1'b0;
  logic offer_beyond = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tb_swap(input logic [31:0] w);
`ifdef GRAY_BURST_WRITER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Bus slave responder plus scoreboard compare, once per cycle on the falling edge.
  initial begin
    forever begin
      logic exp_done;
      @(negedge clk);
      if (i_frameStart) sa = 0;
      else if (sa < 1000) sa++;
      if (!i_nReset) begin
        i_busGrant = 1'b0;
        i_busBusy  = 1'b0;
      end else begin
        i_busGrant = o_busRequest && !o_busDataValid;
        if (o_busDataValid && (beats_frame == stall_beat) && (stall_left > 0)) begin
          i_busBusy = 1'b1;
          stall_left--;
          busy_cycles++;
        end else begin
          i_busBusy = 1'b0;
        end
      end
      if (mon_en) begin
        exp_done = last_prev || (zero_frame && (sa == 2));
        chk("frame_done", 32'(o_frameDone), 32'(exp_done));
        chk("overflow", 32'(o_overflow), 32'(ovf_model));
        last_prev = 1'b0;
        if (o_busDataValid) begin
          chk("request_during_beat", 32'(o_busRequest), 32'd1);
          if (!prev_valid) begin
            rec_addr.push_back(o_busAddress);
            rec_len.push_back(o_busBurstLen);
            rec_data.push_back(o_busData);
          end
          chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            chk("beat_data", o_busData, exp_q[0].data);
            chk("beat_addr", o_busAddress, exp_q[0].addr);
            chk("beat_len", 32'(o_busBurstLen), 32'(exp_q[0].len));
            if (!i_busBusy) begin
              void'(exp_q.pop_front());
              beats_frame++;
              if (exp_q.size() == 0) last_prev = 1'b1;
            end
          end
        end
        if (o_busRequest && (first_req_lat < 0)) first_req_lat = sa;
        if (o_frameDone) begin
          if (done_cnt == 0) done_sa = sa;
          done_cnt++;
        end
        if (i_frameStart) ovf_model = 1'b0;
        else if (i_pixelValid && offer_beyond) ovf_model = 1'b1;
      end
      prev_valid = o_busDataValid;
    end
  end

  // Expected writes: word k lands in burst k/BL at base + 4*BL*(k/BL).
  task automatic start_frame(input logic [31:0] base, input int n, input logic [31:0] d0);
    beat_t b;
    logic [31:0] ab;
    @(posedge clk); #1;
    ab = {base[31:2], 2'b00};
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      b.addr = ab + 32'(4 * BL * (k / BL));
      b.len  = 5'(((n - BL * (k / BL)) < BL) ? (n - BL * (k / BL)) : BL);
      b.data = tb_swap(d0 + 32'(k));
      exp_q.push_back(b);
    end
    rec_addr.delete();
    rec_len.delete();
    rec_data.delete();
    first_req_lat = -1;
    done_cnt = 0;
    done_sa = -1;
    beats_frame = 0;
    zero_frame = (n == 0);
    i_frameStart = 1'b1;
    i_baseAddress = base;
    i_frameWords = 16'(n);
    @(posedge clk); #1;
    i_frameStart = 1'b0;
  endtask

  task automatic send_words(input int n_offer, input int budget, input logic [31:0] d0);
    for (int k = 0; k < n_offer; k++) begin
      i_pixelValid = 1'b1;
      i_pixelWord  = d0 + 32'(k);
      offer_beyond = (k >= budget);
      if (k >= budget) begin
        @(posedge clk); #1;
      end else begin
        int t = 0;
        @(negedge clk);
        while (!o_pixelReady && t < 200) begin
          @(negedge clk);
          t++;
        end
        if (t >= 200) chk("ready_timeout", 32'(o_pixelReady), 32'd1);
        @(posedge clk); #1;
      end
    end
    i_pixelValid = 1'b0;
    offer_beyond = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int t = 0;
    while (done_cnt == 0 && t < limit) begin
      @(negedge clk); #1;
      t++;
    end
    chk("done_timeout", 32'(done_cnt != 0), 32'd1);
    repeat (3) begin
      @(negedge clk); #1;
    end
    chk("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pixelReady"}, 32'(o_pixelReady), 32'd0);
    chk({tag, "_busRequest"}, 32'(o_busRequest), 32'd0);
    chk({tag, "_busDataValid"}, 32'(o_busDataValid), 32'd0);
    chk({tag, "_busData"}, o_busData, 32'd0);
    chk({tag, "_busAddress"}, o_busAddress, 32'd0);
    chk({tag, "_busBurstLen"}, 32'(o_busBurstLen), 32'd0);
    chk({tag, "_frameDone"}, 32'(o_frameDone), 32'd0);
    chk({tag, "_overflow"}, 32'(o_overflow), 32'd0);
  endtask

  initial begin
    int t;
    int bad;
    i_nReset = 1'b0;
    i_frameStart = 1'b0;
    i_baseAddress = '0;
    i_frameWords = '0;
    i_pixelValid = 1'b0;
    i_pixelWord = '0;
    i_busGrant = 1'b0;
    i_busBusy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    i_nReset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Two full bursts at full input rate.
    start_frame(32'h0000_1000, 16, 32'h0302_0100);
    send_words(16, 16, 32'h0302_0100);
    wait_done(400);
    chk("t1_req_latency", 32'(first_req_lat), 32'd10);
    chk("t1_bursts", 32'(rec_addr.size()), 32'd2);
    if (rec_addr.size() == 2) begin
      chk("t1_addr0", rec_addr[0], 32'h0000_1000);
      chk("t1_addr1", rec_addr[1], 32'h0000_1020);
      chk("t1_len0", 32'(rec_len[0]), 32'd8);
      chk("t1_len1", 32'(rec_len[1]), 32'd8);
    end

    // Tail burst of 3.
    start_frame(32'h0000_1000, 11, 32'h0302_0100);
    send_words(11, 11, 32'h0302_0100);
    wait_done(400);
    chk("t2_bursts", 32'(rec_addr.size()), 32'd2);
    if (rec_addr.size() == 2) begin
      chk("t2_addr1", rec_addr[1], 32'h0000_1020);
      chk("t2_len1", 32'(rec_len[1]), 32'd3);
    end

    // Slave stall on beat 4 for 3 cycles.
    stall_beat = 3;
    stall_left = 3;
    busy_cycles = 0;
    start_frame(32'h0000_4000, 8, 32'h0000_00A0);
    send_words(8, 8, 32'h0000_00A0);
    wait_done(400);
    chk("t3_busy_cycles", 32'(busy_cycles), 32'd3);
    chk("t3_beats", 32'(beats_frame), 32'd8);
    stall_beat = -1;

    // Budget overflow: 12 offered, 10 written.
    start_frame(32'h0000_5000, 10, 32'h0000_0100);
    send_words(12, 10, 32'h0000_0100);
    wait_done(400);
    chk("t4_overflow_set", 32'(o_overflow), 32'd1);
    chk("t4_beats", 32'(beats_frame), 32'd10);

    // Empty frame clears overflow and completes one cycle after FILL.
    start_frame(32'h0000_6000, 0, 32'h0);
    wait_done(50);
    chk("t5_overflow_clear", 32'(o_overflow), 32'd0);
    chk("t5_done_cycle", 32'(done_sa), 32'd2);

    // Single-word frame, low address bits ignored, byte order on the bus.
    start_frame(32'h0000_2002, 1, 32'h4433_2211);
    send_words(1, 1, 32'h4433_2211);
    wait_done(200);
    chk("t6_bursts", 32'(rec_addr.size()), 32'd1);
    if (rec_addr.size() == 1) begin
      chk("t6_addr", rec_addr[0], 32'h0000_2000);
      chk("t6_len", 32'(rec_len[0]), 32'd1);
`ifdef GRAY_BURST_WRITER_BYTESWAP_EN
      chk("t6_data", rec_data[0], 32'h1122_3344);
`else
      chk("t6_data", rec_data[0], 32'h4433_2211);
`endif
    end

    // Asynchronous reset in the middle of a burst.
    start_frame(32'h0000_3000, 16, 32'h0000_0500);
    send_words(8, 16, 32'h0000_0500);
    t = 0;
    while (!o_busDataValid && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    chk("t7_burst_started", 32'(o_busDataValid), 32'd1);
    @(posedge clk); #2;
    mon_en = 1'b0;
    i_nReset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk); #1;
    i_nReset = 1'b1;
    exp_q.delete();
    bad = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (o_frameDone || o_busRequest || o_pixelReady) bad++;
    end
    chk("t7_quiet_after_reset", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gray_burst_writer.md
# gray_burst_writer

Downstream stage of the RGB565-to-grayscale converter: accepts packed grayscale words (four 8-bit pixels per 32-bit word) and writes them to frame memory in fixed-length bursts. Words are buffered in an internal FIFO and counted against a per-frame word budget. The block then issues bursts through a request/grant bus-master handshake. It lets the CPU or camera path hand off grayscale results without stalling on memory latency.

## Interface
- `BURST_LEN`, 8: words per bus burst (power of two, 2..16).
- `FIFO_DEPTH`, 16: buffer depth in words (power of two, ≥ 2·BURST_LEN).
- `clock`  in  1  system clock, all logic rising-edge.
- `nReset`  in  1  asynchronous active-low reset.
- `frameStart`  in  1  one-cycle pulse: latch `baseAddress`/`frameWords`, restart frame.
- `baseAddress`  in  32  word-aligned frame base (bits [1:0] ignored, treated 0).
- `frameWords`  in  16  words in this frame; 0 = frame completes immediately.
- `pixelValid`  in  1  input word valid.
- `pixelWord`  in  32  four grayscale pixels, pixel 0 in [7:0].
- `pixelReady`  out  1  FIFO can accept; transfer when valid&ready.
- `busRequest`  out  1  bus ownership request.
- `busGrant`  in  1  bus granted.
- `busAddress`  out  32  burst start address, valid with `busRequest`.
- `busBurstLen`  out  5  beats in current burst (1..BURST_LEN).
- `busData`  out  32  write data.
- `busDataValid`  out  1  data beat presented.
- `busBusy`  in  1  slave stall; beat held while high.
- `frameDone`  out  1  one-cycle pulse after last beat of frame.
- `overflow`  out  1  sticky: word offered beyond `frameWords`; cleared by `frameStart`.

## Operation
- Reset: all outputs 0, state IDLE, FIFO empty, counters 0, `pixelReady` 0.
- `frameStart` (any state, highest priority except reset): FIFO flushed, outstanding burst abandoned (`busRequest`/`busDataValid` drop next cycle), address and remaining-word counters loaded, state FILL.
- `pixelReady` = state≠IDLE & FIFO not full & accepted-word count < `frameWords`. Valid while not ready past budget sets `overflow`; word dropped.
- States:
  - IDLE: wait for `frameStart`.
  - FILL: go to REQ when FIFO count ≥ BURST_LEN, or when all remaining frame words are in FIFO (tail burst, count ≥ 1).
  - REQ: `busRequest`=1, `busAddress`=current address, `busBurstLen`=min(BURST_LEN, remaining). On `busGrant` → BURST.
  - BURST: `busRequest` stays 1; FIFO head on `busData`, `busDataValid`=1. A beat completes on a cycle with `busBusy`=0; pop and advance. After the final beat: address += 4·len, remaining −= len. Next state is DONE if remaining=0, else FILL.
  - DONE: `frameDone` pulse, → IDLE.
- Simultaneous push and pop keep the count unchanged. Pop on empty never occurs by construction; assert in simulation.
- Address wraps modulo 2^32; no boundary splitting.
- `frameWords`=0: FILL → DONE directly, `frameDone` one cycle after entering FILL.

## Timing
- Push-to-FIFO: registered, word visible at head next cycle.
- Minimum `frameStart`→`busRequest`: BURST_LEN+2 cycles at full input rate.
- `busGrant`→first beat: 1 cycle. Beats sustain 1/cycle when `busBusy`=0.
- `busBusy` sampled same cycle as `busDataValid`; data held stable while busy.
- `frameDone` asserted the cycle after last beat accepted.

## Configuration
- `GRAY_BURST_WRITER_BYTESWAP_EN`: defined → `busData` is the FIFO word byte-reversed ([7:0]↔[31:24], [15:8]↔[23:16]) for the big-endian CPU view; undefined → passed unchanged. Nothing else differs.

## Structure
- Shared package `gray_writer_pkg`: state enum (IDLE, FILL, REQ, BURST, DONE), `BYTES_PER_WORD`=4, byte-swap function.
- Sub-module `gray_word_fifo` (synchronous FIFO, parameter depth, push/pop/count/flush), instantiated once.

## Test plan
- Reset mid-BURST (nReset low 1 cycle) → all outputs 0 asynchronously, IDLE, no `frameDone`.
- frameWords=16, BURST_LEN=8, base 0x1000, continuous input 0x03020100+k → two bursts at 0x1000 and 0x1020, len 8, data in order, one `frameDone`.
- frameWords=11 → bursts of 8 then 3 at 0x1020, `busBurstLen`=3.
- `busBusy` high 3 cycles on beat 4 → beat 4 data held, no duplicate or skipped word.
- 12 words offered with frameWords=10 → `overflow`=1, words 10–11 dropped, exactly 10 written; next `frameStart` clears `overflow`.
- With BYTESWAP_EN, input 0x44332211 → `busData`=0x11223344; without → 0x44332211.
